// File: rtl/echo_delay_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : echo_delay_ctrl_if
// Description : Port bundle between the echo delay sequencer and its
//               synchronous FIFO (1-cycle read latency).
// Revision    : 1.0  initial release
// ============================================================================
interface echo_delay_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              fifo_wr_en;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full;
  logic              fifo_empty;

  // Sequencer side: owns the enables, observes data and flags
  modport master (
    output fifo_wr_en,
    output fifo_wr_data,
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_full,
    input  fifo_empty
  );

  // FIFO side
  modport slave (
    input  fifo_wr_en,
    input  fifo_wr_data,
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_full,
    output fifo_empty
  );
endinterface
`default_nettype wire

// File: rtl/echo_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : echo_delay_ctrl
// Description : Sequencer for the FIFO-based echo delay line. Keeps FIFO
//               occupancy equal to the programmed delay (fill / run / drain)
//               and emits one output sample exactly 1 clk after each input.
//               Optional macro ECHO_MIX_EN: mix dry input with attenuated
//               delayed sample (per 16-bit channel, saturating).
// Revision    : 1.0  initial release
// ============================================================================
module echo_delay_ctrl #(
  parameter int DATA_W        = 32,
  parameter int DEPTH_W       = 12,
  parameter int DEFAULT_DELAY = 1024,
  parameter int ATTEN_SHIFT   = 1
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  input  wire logic               sample_valid,
  input  wire logic [DATA_W-1:0]  sample_in,
  input  wire logic [DEPTH_W-1:0] delay_num,
  input  wire logic               delay_update,
  echo_delay_ctrl_if.master       fifo,
  output logic      [DATA_W-1:0]  sample_out,
  output logic                    sample_out_valid,
  output logic      [DEPTH_W:0]   occupancy,
  output logic      [1:0]         state_o,
  output logic                    err
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Source of the sample presented 1 clk after sample_valid
  localparam logic [1:0] MODE_ZERO = 2'd0;  // fill: silence (or dry when mixing)
  localparam logic [1:0] MODE_FIFO = 2'd1;  // delayed sample from FIFO Q
  localparam logic [1:0] MODE_PASS = 2'd2;  // zero delay: registered input

  // A target wider than the FIFO can hold is clamped to the largest count
  localparam logic [DEPTH_W-1:0] DEFAULT_TGT =
    (DEFAULT_DELAY > (1 << DEPTH_W) - 1) ? {DEPTH_W{1'b1}} : DEPTH_W'(DEFAULT_DELAY);

  state_t             state, state_nxt;
  logic [DEPTH_W-1:0] target, target_nxt;
  logic [DEPTH_W:0]   occ, occ_nxt;
  logic               wr_req, rd_req, wr_ok, rd_ok, viol;
  logic [1:0]         mode_nxt, out_mode;
  logic               out_valid;
  logic               err_r;
  logic [DATA_W-1:0]  in_d;
  logic [DATA_W-1:0]  out_sel;

  // One 16-bit channel: dry + (wet >>> ATTEN_SHIFT), saturated to int16
  function automatic logic [15:0] mix16(input logic [15:0] dry, input logic [15:0] wet);
    logic signed [15:0] att;
    logic signed [16:0] sum;
    att = $signed(wet) >>> ATTEN_SHIFT;
    sum = $signed({dry[15], dry}) + $signed({att[15], att});
    if (sum > 17'sd32767)
      mix16 = 16'h7FFF;
    else if (sum < -17'sd32768)
      mix16 = 16'h8000;
    else
      mix16 = sum[15:0];
  endfunction

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= FILL;
    else
      state <= state_nxt;
  end

  // FIFO access decision, protection, occupancy/target update and next-state
  always_comb begin
    wr_req   = 1'b0;
    rd_req   = 1'b0;
    mode_nxt = MODE_ZERO;
    if (sample_valid) begin
      case (state)
        FILL: begin
          wr_req   = 1'b1;
          mode_nxt = MODE_ZERO;
        end
        RUN: begin
          if (target == '0) begin
            mode_nxt = MODE_PASS;
          end else begin
            wr_req   = 1'b1;
            rd_req   = 1'b1;
            mode_nxt = MODE_FIFO;
          end
        end
        DRAIN: begin
          wr_req   = 1'b1;
          rd_req   = 1'b1;
          mode_nxt = MODE_FIFO;
        end
        default: mode_nxt = MODE_ZERO;
      endcase
    end else if (state == DRAIN) begin
      // idle clock while too full: discard one word
      rd_req = 1'b1;
    end

    // Reads are gated by empty first; a write into a full FIFO is only safe
    // when a read frees a word in the same clock.
    rd_ok = rd_req & ~fifo.fifo_empty;
    wr_ok = wr_req & ~(fifo.fifo_full & ~rd_ok);
    viol  = (rd_req & fifo.fifo_empty) | (wr_req & fifo.fifo_full & ~rd_ok);

    case ({wr_ok, rd_ok})
      2'b10:   occ_nxt = occ + 1'b1;
      2'b01:   occ_nxt = occ - 1'b1;
      default: occ_nxt = occ;
    endcase

    // delay_num is DEPTH_W wide, so it never exceeds the clamp limit
    target_nxt = delay_update ? delay_num : target;

    // State always reflects the occupancy/target pair in force next clock
    if (occ_nxt < {1'b0, target_nxt})
      state_nxt = FILL;
    else if (occ_nxt == {1'b0, target_nxt})
      state_nxt = RUN;
    else
      state_nxt = DRAIN;
  end

  // Occupancy, target, sticky error and output-alignment registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ       <= '0;
      target    <= DEFAULT_TGT;
      err_r     <= 1'b0;
      out_valid <= 1'b0;
      out_mode  <= MODE_ZERO;
      in_d      <= '0;
    end else begin
      occ       <= occ_nxt;
      target    <= target_nxt;
      out_valid <= sample_valid;
      out_mode  <= mode_nxt;
      if (viol)
        err_r <= 1'b1;
      if (sample_valid)
        in_d <= sample_in;
    end
  end

  // Output selection; FIFO Q is valid in the clock after the read
  always_comb begin
    out_sel = '0;
`ifdef ECHO_MIX_EN
    case (out_mode)
      MODE_FIFO: out_sel = {mix16(in_d[DATA_W-1:DATA_W-16], fifo.fifo_rd_data[DATA_W-1:DATA_W-16]),
                            mix16(in_d[15:0], fifo.fifo_rd_data[15:0])};
      default:   out_sel = in_d;
    endcase
`else
    case (out_mode)
      MODE_FIFO: out_sel = fifo.fifo_rd_data;
      MODE_PASS: out_sel = in_d;
      default:   out_sel = '0;
    endcase
`endif
  end

  assign fifo.fifo_wr_en   = wr_ok;
  assign fifo.fifo_wr_data = sample_in;
  assign fifo.fifo_rd_en   = rd_ok;

  assign sample_out       = out_valid ? out_sel : '0;
  assign sample_out_valid = out_valid;
  assign occupancy        = occ;
  assign state_o          = state;
  assign err              = err_r;

endmodule
`default_nettype wire

// File: tb/tb_echo_delay_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_echo_delay_ctrl
// Description : Self-checking bench for echo_delay_ctrl with a behavioural
//               FIFO and a queue-based reference model of the delay line.
// Revision    : 1.0  initial release
// ============================================================================
module tb_echo_delay_ctrl;
  localparam int DATA_W        = 32;
  localparam int DEPTH_W       = 4;
  localparam int DEFAULT_DELAY = 4;
  localparam int ATTEN_SHIFT   = 1;
  localparam int DEPTH         = 1 << DEPTH_W;

  logic               clk          = 1'b0;
  logic               reset_n      = 1'b0;
  logic               sample_valid = 1'b0;
  logic [DATA_W-1:0]  sample_in    = '0;
  logic [DEPTH_W-1:0] delay_num    = '0;
  logic               delay_update = 1'b0;
  logic               force_full   = 1'b0;
  logic [DATA_W-1:0]  sample_out;
  logic               sample_out_valid;
  logic [DEPTH_W:0]   occupancy;
  logic [1:0]         state_o;
  logic               err;

  echo_delay_ctrl_if #(.DATA_W(DATA_W)) fbus ();

  echo_delay_ctrl #(
    .DATA_W       (DATA_W),
    .DEPTH_W      (DEPTH_W),
    .DEFAULT_DELAY(DEFAULT_DELAY),
    .ATTEN_SHIFT  (ATTEN_SHIFT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sample_valid    (sample_valid),
    .sample_in       (sample_in),
    .delay_num       (delay_num),
    .delay_update    (delay_update),
    .fifo            (fbus.master),
    .sample_out      (sample_out),
    .sample_out_valid(sample_out_valid),
    .occupancy       (occupancy),
    .state_o         (state_o),
    .err             (err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural synchronous FIFO ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  int                fcnt, wp, rp;
  logic [DATA_W-1:0] q;
  wire rd_go = fbus.fifo_rd_en && (fcnt != 0);
  wire wr_go = fbus.fifo_wr_en && ((fcnt != DEPTH) || rd_go);

  // FIFO storage, pointers and registered read data
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fcnt <= 0; wp <= 0; rp <= 0; q <= '0;
    end else begin
      if (rd_go) begin q <= mem[rp]; rp <= (rp + 1) % DEPTH; end
      if (wr_go) begin mem[wp] <= fbus.fifo_wr_data; wp <= (wp + 1) % DEPTH; end
      fcnt <= fcnt + (wr_go ? 1 : 0) - (rd_go ? 1 : 0);
    end
  end

  assign fbus.fifo_rd_data = q;
  assign fbus.fifo_full    = (fcnt == DEPTH) || force_full;
  assign fbus.fifo_empty   = (fcnt == 0);

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  logic [DATA_W-1:0] got[$];
  logic [DATA_W-1:0] exp_q[$];

  // compare the output samples captured since the last clear with exp_q
  task automatic chk_seq(input string name);
    chk({name, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk(name, (i < got.size()) ? {32'd0, got[i]} : 64'hDEAD_BEEF_DEAD_BEEF, {32'd0, exp_q[i]});
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mq[$];  // ideal delay-line contents, oldest first
  int                tgt;
  bit                m_err;
  bit                exp_valid;
  bit                exp_known;
  logic [DATA_W-1:0] exp_out;
  int                exp_state;

  function automatic int cls(input int occ, input int t);
    if (occ < t) return 0;
    if (occ == t) return 1;
    return 2;
  endfunction

  function automatic logic [15:0] sat_ch(input logic [15:0] dry, input logic [15:0] wet);
    int s;
    s = int'($signed(dry)) + (int'($signed(wet)) >>> ATTEN_SHIFT);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  function automatic logic [DATA_W-1:0] mixm(input logic [DATA_W-1:0] dry, input logic [DATA_W-1:0] wet);
    return {sat_ch(dry[31:16], wet[31:16]), sat_ch(dry[15:0], wet[15:0])};
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        mq.delete();
        tgt = DEFAULT_DELAY; m_err = 0; exp_valid = 0; exp_known = 1;
        exp_out = '0; exp_state = 0;
        chk("rst_valid", sample_out_valid, 0);
        chk("rst_out", sample_out, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_state", state_o, 0);
        chk("rst_err", err, 0);
        chk("rst_wr_en", fbus.fifo_wr_en, 0);
        chk("rst_rd_en", fbus.fifo_rd_en, 0);
      end else begin
        int st;
        bit wr, rd, full, empty;
        logic [DATA_W-1:0] popped;

        chk("valid", sample_out_valid, exp_valid);
        if (exp_valid && exp_known) chk("sample_out", sample_out, exp_out);
        chk("occupancy", occupancy, mq.size());
        chk("state", state_o, exp_state);
        chk("err", err, m_err);
        if (sample_out_valid) got.push_back(sample_out);

        // what must happen on the coming clock edge
        st = cls(mq.size(), tgt);
        wr = 0; rd = 0; popped = '0;
        full  = (mq.size() == DEPTH) || force_full;
        empty = (mq.size() == 0);
        exp_known = 1;
`ifdef ECHO_MIX_EN
        exp_out = sample_in;
`else
        exp_out = '0;
`endif
        if (sample_valid) begin
          if (st == 0) wr = 1;
          else if (st == 1 && tgt == 0) exp_out = sample_in;
          else begin wr = 1; rd = 1; end
        end else if (st == 2) begin
          rd = 1;
        end
        if (rd && empty) begin rd = 0; m_err = 1; exp_known = 0; end
        if (wr && full && !rd) begin wr = 0; m_err = 1; end

        chk("wr_en", fbus.fifo_wr_en, wr);
        chk("rd_en", fbus.fifo_rd_en, rd);
        if (wr) chk("wr_data", fbus.fifo_wr_data, sample_in);

        if (rd) popped = mq.pop_front();
        if (wr) mq.push_back(sample_in);
        if (sample_valid && (st != 0) && !(st == 1 && tgt == 0)) begin
`ifdef ECHO_MIX_EN
          exp_out = mixm(sample_in, popped);
`else
          exp_out = popped;
`endif
        end
        exp_valid = sample_valid;
        if (delay_update) tgt = delay_num;
        exp_state = cls(mq.size(), tgt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [DATA_W-1:0] v);
    sample_valid = 1'b1; sample_in = v;
    tick(1);
    sample_valid = 1'b0;
    tick(3);
  endtask

  task automatic retarget(input int d);
    delay_num = DEPTH_W'(d); delay_update = 1'b1;
    tick(1);
    delay_update = 1'b0;
  endtask

  initial begin
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // T1: default delay 4, samples 1..10
    got.delete();
    for (int i = 1; i <= 10; i++) begin
      send(DATA_W'(i));
      if (i == 3) chk("t1_state_fill", state_o, 0);
      if (i == 4) chk("t1_state_run", state_o, 1);
    end
    chk("t1_occ", occupancy, 4);
`ifndef ECHO_MIX_EN
    exp_q = '{0, 0, 0, 0, 1, 2, 3, 4, 5, 6};
    chk_seq("t1_out");
`endif

    // T2: grow to 8, then shrink to 3 while idle
    retarget(8);
    for (int i = 11; i <= 14; i++) send(DATA_W'(i));
    chk("t2_occ8", occupancy, 8);
    chk("t2_state8", state_o, 1);
    retarget(3);
    tick(8);
    chk("t2_occ3", occupancy, 3);
    chk("t2_state3", state_o, 1);
    got.delete();
    send(15);
`ifndef ECHO_MIX_EN
    exp_q = '{12};
    chk_seq("t2_out");
`endif

    // T3: delay 3 -> 6
    retarget(6);
    got.delete();
    for (int i = 16; i <= 19; i++) send(DATA_W'(i));
`ifndef ECHO_MIX_EN
    exp_q = '{0, 0, 0, 13};
    chk_seq("t3_out");
`endif
    chk("t3_occ", occupancy, 6);

    // T4: zero delay -> drain, then passthrough
    retarget(0);
    tick(8);
    chk("t4_occ", occupancy, 0);
    chk("t4_state", state_o, 1);
    got.delete();
    send(20);
    send(21);
    exp_q = '{20, 21};
    chk_seq("t4_out");

    // T5: forced full during FILL
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    force_full = 1'b1;
    sample_valid = 1'b1; sample_in = 30;
    #2;
    chk("t5_wr_blocked", fbus.fifo_wr_en, 0);
    tick(1);
    sample_valid = 1'b0;
    force_full = 1'b0;
    chk("t5_err_set", err, 1);
    tick(5);
    chk("t5_err_sticky", err, 1);
    chk("t5_occ", occupancy, 0);
    reset_n = 1'b0;
    tick(1);
    chk("t5_err_cleared", err, 0);
    reset_n = 1'b1;
    tick(1);

`ifdef ECHO_MIX_EN
    // T6: saturating mix at delay 1
    retarget(1);
    got.delete();
    send(32'h7000_FF9C);
    send(32'h7000_FF9C);
    exp_q = '{32'h7000_FF9C, 32'h7FFF_FF6A};
    chk_seq("t6_mix");
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
